fp16_seq_divider: RTL and testbench



---
 rtl/fp16_pkg.sv | 29 ++
 rtl/fp16_div_normalize.sv | 75 +++++++
 rtl/fp16_seq_divider.sv | 147 ++++++++++++++
 tb/tb_fp16_seq_divider.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 field widths, constants and the sequential divider's FSM encoding.
// FP16_DIV_ROUND_EN adds one guard iteration so the divider can round to nearest even.
package fp16_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;

    localparam logic [15:0] FP16_ZERO    = 16'h0000;
    localparam logic [4:0]  FP16_INF_EXP = 5'h1F;

    // Remainder holds {0, hidden 1, mantissa} so a shifted remainder never overflows.
    localparam int FP16_SIG_W = FP16_MAN_W + 2;

`ifdef FP16_DIV_ROUND_EN
    localparam int DIV_ITERS = FP16_SIG_W + 1;
`else
    localparam int DIV_ITERS = FP16_SIG_W;
`endif

    localparam int DIV_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp16_div_normalize.sv
// Maps the raw restoring-divider quotient plus exponents/sign/zero flags to an fp16 result.
// With FP16_DIV_ROUND_EN the extra quotient bit and remainder feed round-to-nearest-even.
module fp16_div_normalize
    import fp16_pkg::*;
(
    input  logic [DIV_ITERS-1:0]  q_i,
    input  logic [FP16_EXP_W-1:0] e1_i,
    input  logic [FP16_EXP_W-1:0] e2_i,
    input  logic                  sign_i,
    input  logic                  a_zero_i,
    input  logic                  b_zero_i,
`ifdef FP16_DIV_ROUND_EN
    input  logic                  rem_nz_i,
`endif
    output logic [15:0]           op_o,
    output logic                  div_by_zero_o
);

    logic [FP16_EXP_W-1:0] exp_base;
    logic [FP16_EXP_W-1:0] exp_res;
    logic [FP16_MAN_W-1:0] man_res;

    // Exponent arithmetic wraps modulo 32, matching the companion multiplier.
    assign exp_base = e1_i - e2_i;

`ifdef FP16_DIV_ROUND_EN
    logic [FP16_EXP_W-1:0] exp_pre;
    logic [FP16_MAN_W-1:0] man_pre;
    logic [FP16_MAN_W:0]   man_inc;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;

    always_comb begin
        if (q_i[DIV_ITERS-1]) begin
            man_pre = q_i[DIV_ITERS-2 -: FP16_MAN_W];
            guard   = q_i[1];
            sticky  = q_i[0] | rem_nz_i;
            exp_pre = exp_base + FP16_EXP_W'(FP16_BIAS);
        end else begin
            man_pre = q_i[DIV_ITERS-3 -: FP16_MAN_W];
            guard   = q_i[0];
            sticky  = rem_nz_i;
            exp_pre = exp_base + FP16_EXP_W'(FP16_BIAS - 1);
        end
        round_up = guard & (sticky | man_pre[0]);
        man_inc  = {1'b0, man_pre} + {{FP16_MAN_W{1'b0}}, round_up};
        man_res  = man_inc[FP16_MAN_W-1:0];
        exp_res  = exp_pre + {{(FP16_EXP_W-1){1'b0}}, man_inc[FP16_MAN_W]};
    end
`else
    always_comb begin
        if (q_i[DIV_ITERS-1]) begin
            man_res = q_i[DIV_ITERS-2 -: FP16_MAN_W];
            exp_res = exp_base + FP16_EXP_W'(FP16_BIAS);
        end else begin
            man_res = q_i[DIV_ITERS-3 -: FP16_MAN_W];
            exp_res = exp_base + FP16_EXP_W'(FP16_BIAS - 1);
        end
    end
`endif

    // A zero divisor wins over a zero dividend, so 0/0 also reports div_by_zero.
    always_comb begin
        op_o          = {sign_i, exp_res, man_res};
        div_by_zero_o = 1'b0;
        if (b_zero_i) begin
            op_o          = {sign_i, FP16_INF_EXP, {FP16_MAN_W{1'b0}}};
            div_by_zero_o = 1'b1;
        end else if (a_zero_i) begin
            op_o = FP16_ZERO;
        end
    end

endmodule

// File: rtl/fp16_seq_divider.sv
// Sequential fp16 divider (op = in1 / in2): restoring mantissa division, one quotient bit per clock.
// FP16_DIV_ROUND_EN selects a 13-iteration round-to-nearest-even build; default truncates in 12.
module fp16_seq_divider
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] op,
    output logic        div_by_zero
);

    localparam int EXP_W = FP16_EXP_W;
    localparam int MAN_W = FP16_MAN_W;
    localparam int SIG_W = FP16_SIG_W;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic                   a_zero_q, a_zero_d;
    logic                   b_zero_q, b_zero_d;
    logic [EXP_W-1:0]       e1_q, e1_d;
    logic [EXP_W-1:0]       e2_q, e2_d;
    logic [MAN_W:0]         m2_q, m2_d;
    logic [SIG_W-1:0]       rem_q, rem_d;
    logic [DIV_ITERS-1:0]   quo_q, quo_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]            op_q, op_d;
    logic                   dbz_q, dbz_d;

    logic                   rem_ge;
    logic [SIG_W-1:0]       rem_sel;
    logic [SIG_W-1:0]       rem_step;
    logic [DIV_ITERS-1:0]   quo_step;
    logic [15:0]            norm_op;
    logic                   norm_dbz;

    // One restoring step; quotient bits land MSB-first at position (ITERS-1-cnt).
    always_comb begin
        rem_ge   = rem_q >= {1'b0, m2_q};
        rem_sel  = rem_ge ? (rem_q - {1'b0, m2_q}) : rem_q;
        rem_step = rem_sel << 1;
        quo_step = quo_q;
        quo_step[DIV_CNT_W'(DIV_ITERS - 1) - cnt_q] = rem_ge;
    end

    fp16_div_normalize u_normalize (
        .q_i           (quo_step),
        .e1_i          (e1_q),
        .e2_i          (e2_q),
        .sign_i        (sign_q),
        .a_zero_i      (a_zero_q),
        .b_zero_i      (b_zero_q),
`ifdef FP16_DIV_ROUND_EN
        .rem_nz_i      (|rem_step),
`endif
        .op_o          (norm_op),
        .div_by_zero_o (norm_dbz)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no branch of this block can infer a latch.
        state_d  = state_q;
        sign_d   = sign_q;
        a_zero_d = a_zero_q;
        b_zero_d = b_zero_q;
        e1_d     = e1_q;
        e2_d     = e2_q;
        m2_d     = m2_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_DIV;
                    sign_d   = in1[15] ^ in2[15];
                    a_zero_d = (in1 == FP16_ZERO);
                    b_zero_d = (in2 == FP16_ZERO);
                    e1_d     = in1[14:10];
                    e2_d     = in2[14:10];
                    m2_d     = {1'b1, in2[MAN_W-1:0]};
                    rem_d    = {1'b0, 1'b1, in1[MAN_W-1:0]};
                    quo_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
                    state_d = ST_DONE;
                    op_d    = norm_op;
                    dbz_d   = norm_dbz;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            e1_q     <= '0;
            e2_q     <= '0;
            m2_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            op_q     <= FP16_ZERO;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            a_zero_q <= a_zero_d;
            b_zero_q <= b_zero_d;
            e1_q     <= e1_d;
            e2_q     <= e2_d;
            m2_q     <= m2_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign op          = op_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp16_seq_divider.sv
// Directed scoreboard bench for fp16_seq_divider; expectations are hand-derived constants.
// Build with FP16_DIV_ROUND_EN defined to exercise the rounding variant.
module tb_fp16_seq_divider;

`ifdef FP16_DIV_ROUND_EN
    localparam int LAT = 13;
    localparam bit ROUND = 1'b1;
`else
    localparam int LAT = 12;
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in1 = 16'h0000;
    logic [15:0] in2 = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] op;
    logic        div_by_zero;

    always #5 clk = ~clk;

    fp16_seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op          (op),
        .div_by_zero (div_by_zero)
    );

    typedef struct packed {
        logic [15:0] op;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Present operands, wait (bounded) for acceptance, queue the expected result.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eop, input logic edbz);
        int w = 0;
        @(negedge clk);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_in_ready", in_ready, 1);
        sb_q.push_back(exp_t'{eop, edbz});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = 16'($urandom);
        in2 = 16'($urandom);
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall, then release.
    task automatic collect(input string tag, input int hold);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        if (sb_q.size() == 0) begin
            n_total++;
            $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_op"}, op, e.op);
            check({tag, "_dbz"}, div_by_zero, e.dbz);
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                in1 = 16'($urandom);
                in2 = 16'($urandom);
                @(posedge clk);
                #1;
                check({tag, "_hold_op"}, op, e.op);
                check({tag, "_hold_in_ready"}, in_ready, 0);
                check({tag, "_hold_out_valid"}, out_valid, 1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_release_in_ready"}, in_ready, 1);
        check({tag, "_release_out_valid"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_op", op, 16'h0000);
        check("reset_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(16'h4200, 16'h3E00, 16'h4000, 1'b0); collect("3_by_1p5", 0);
        issue(16'h3C00, 16'h4200, 16'h3555, 1'b0); collect("1_by_3", 0);
        issue(16'hC600, 16'h4000, 16'hC200, 1'b0); collect("m6_by_2", 0);
        issue(16'h3C00, 16'h4000, 16'h3800, 1'b0); collect("1_by_2", 0);
        issue(16'h0000, 16'h4000, 16'h0000, 1'b0); collect("0_by_2", 0);
        issue(16'hC200, 16'h0000, 16'hFC00, 1'b1); collect("m3_by_0", 0);
        issue(16'h0000, 16'h0000, 16'h7C00, 1'b1); collect("0_by_0", 0);
        // -0 is not a zero operand; exponent 0-16+15 wraps to 31.
        issue(16'h8000, 16'h4000, 16'hFC00, 1'b0); collect("negzero_wrap", 0);
        issue(16'h3C00, 16'h3BFF, ROUND ? 16'h3C01 : 16'h3C00, 1'b0); collect("round_case", 0);
        issue(16'h3C01, 16'h3C00, 16'h3C01, 1'b0); collect("exact_1ulp", 0);

        // Backpressure with operand churn, then back-to-back operations.
        issue(16'h4500, 16'h4000, 16'h4100, 1'b0); collect("backpressure", 5);
        issue(16'h3C00, 16'h4000, 16'h3800, 1'b0); collect("b2b_first", 0);
        issue(16'hC600, 16'h4000, 16'hC200, 1'b0); collect("b2b_second", 0);

        // Reset at iteration 6 aborts the operation with no result.
        @(negedge clk);
        in1 = 16'h4200;
        in2 = 16'h3E00;
        in_valid = 1'b1;
        check("abort_accept_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        issue(16'h4000, 16'h3C00, 16'h4000, 1'b0); collect("after_abort", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
